// File: rtl/code_stream_checker.sv
// Code stream checker: decodes a stream of 4-bit code words (Gray, Excess-3, binary or BCD)
// and verifies each decoded index follows its predecessor by one, modulo the code's range.
module code_stream_checker #(
  parameter int unsigned NUM_WORDS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] select,
  input  logic       code_valid,
  input  logic [3:0] code_in,
  output logic       code_ready,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [4:0] word_count,
  output logic [3:0] last_index,
  output logic       code_error
);

  localparam logic [4:0] NumWordsW = 5'(NUM_WORDS);

  typedef enum logic [1:0] {StIdle, StFirst, StCheck, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       code_ready_q, code_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [4:0] err_count_q, err_count_d;
  logic [4:0] word_count_q, word_count_d;
  logic [3:0] last_index_q, last_index_d;
  logic       code_error_q, code_error_d;

  logic       xfer;
  logic       legal;
  logic [3:0] idx;
  logic [3:0] expected;
  logic [4:0] err_inc;

  assign xfer    = code_valid && code_ready_q;
  assign err_inc = (err_count_q == 5'd31) ? 5'd31 : err_count_q + 5'd1;

  // Decode the incoming word under the latched code type; illegal words decode to 0.
  always_comb begin
    legal = 1'b1;
    idx   = 4'd0;
    unique case (sel_q)
      2'b00: idx = {code_in[3], ^code_in[3:2], ^code_in[3:1], ^code_in[3:0]};
      2'b01: begin
        legal = (code_in >= 4'd3) && (code_in <= 4'd12);
        idx   = legal ? code_in - 4'd3 : 4'd0;
      end
      2'b10: idx = code_in;
      2'b11: begin
        legal = (code_in <= 4'd9);
        idx   = legal ? code_in : 4'd0;
      end
      default: idx = 4'd0;
    endcase
    // Excess-3 and BCD (select bit 0 set) count modulo 10, the others wrap naturally at 16.
    if (sel_q[0] && (last_index_q == 4'd9)) begin
      expected = 4'd0;
    end else begin
      expected = last_index_q + 4'd1;
    end
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    err_count_d  = err_count_q;
    word_count_d = word_count_q;
    last_index_d = last_index_q;
    code_error_d = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sel_d        = select;
          err_count_d  = 5'd0;
          word_count_d = 5'd0;
          last_index_d = 4'd0;
          state_d      = StFirst;
        end
      end
      StFirst: begin
        if (xfer) begin
          last_index_d = idx;
          word_count_d = 5'd1;
          if (!legal) begin
            err_count_d  = err_inc;
            code_error_d = 1'b1;
          end
          state_d = (NUM_WORDS == 1) ? StDone : StCheck;
        end
      end
      StCheck: begin
        if (xfer) begin
          if (!legal || (idx != expected)) begin
            err_count_d = err_inc;
          end
          code_error_d = !legal;
          // Resync on an illegal word so a single bad word costs exactly one error.
          last_index_d = legal ? idx : expected;
          word_count_d = word_count_q + 5'd1;
          if (word_count_q + 5'd1 == NumWordsW) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    code_ready_d = (state_d == StFirst) || (state_d == StCheck);
    busy_d       = code_ready_d;
    done_d       = (state_d == StDone);
    pass_d       = done_d && (err_count_d == 5'd0);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      sel_q        <= 2'b00;
      code_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= 5'd0;
      word_count_q <= 5'd0;
      last_index_q <= 4'd0;
      code_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      code_ready_q <= code_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
      last_index_q <= last_index_d;
      code_error_q <= code_error_d;
    end
  end

  assign code_ready = code_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign word_count = word_count_q;
  assign last_index = last_index_q;
  assign code_error = code_error_q;

endmodule

// File: tb/tb_code_stream_checker.sv
// Scoreboard bench for code_stream_checker: a driver pushes the reference model's expected
// per-word response, a monitor pops and compares after every observed transfer.
module tb_code_stream_checker;

  localparam int unsigned NW = 16;

  logic       clk = 1'b0;
  logic       rst, start, code_valid;
  logic [1:0] select;
  logic [3:0] code_in;
  logic       code_ready, busy, done, pass, code_error;
  logic [4:0] err_count, word_count;
  logic [3:0] last_index;

  code_stream_checker #(.NUM_WORDS(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .select     (select),
    .code_valid (code_valid),
    .code_in    (code_in),
    .code_ready (code_ready),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .word_count (word_count),
    .last_index (last_index),
    .code_error (code_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int li;
    int ec;
    int wc;
    int ce;
    int dn;
    int ps;
    int bs;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_errs   = 0;
  int ce_count = 0;

  // Reference model state
  int m_sel, m_last, m_err, m_cnt;
  bit m_first;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int modulus(input int sel);
    return (sel == 1 || sel == 3) ? 10 : 16;
  endfunction

  function automatic int encode(input int sel, input int v);
    case (sel)
      0:       return v ^ (v >> 1);
      1:       return v + 3;
      default: return v;
    endcase
  endfunction

  task automatic model_decode(input int sel, input int code, output bit legal, output int idx);
    case (sel)
      0: begin legal = 1; idx = (code ^ (code >> 1) ^ (code >> 2) ^ (code >> 3)) & 15; end
      1: begin legal = (code >= 3 && code <= 12); idx = legal ? code - 3 : 0; end
      2: begin legal = 1; idx = code; end
      default: begin legal = (code <= 9); idx = legal ? code : 0; end
    endcase
  endtask

  task automatic model_step(input int code);
    bit   legal;
    int   idx, want;
    bit   bad;
    exp_t e;
    model_decode(m_sel, code, legal, idx);
    if (m_first) begin
      bad     = !legal;
      m_last  = idx;
      m_cnt   = 1;
      m_first = 0;
    end else begin
      want   = (m_last + 1) % modulus(m_sel);
      bad    = !legal || (idx != want);
      m_last = legal ? idx : want;
      m_cnt++;
    end
    if (bad && m_err < 31) m_err++;
    e.li = m_last;
    e.ec = m_err;
    e.wc = m_cnt;
    e.ce = legal ? 0 : 1;
    e.dn = (m_cnt == NW) ? 1 : 0;
    e.ps = (e.dn == 1 && m_err == 0) ? 1 : 0;
    e.bs = e.dn ? 0 : 1;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted word must have a matching expected response.
  always @(posedge clk) begin
    if (!rst && code_valid && code_ready) begin
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_transfer: got transfer of %0d, expected none", code_in);
      end else begin
        mon_e = exp_q.pop_front();
        check("xfer_last_index", last_index, mon_e.li);
        check("xfer_err_count", err_count, mon_e.ec);
        check("xfer_word_count", word_count, mon_e.wc);
        check("xfer_code_error", code_error, mon_e.ce);
        check("xfer_done", done, mon_e.dn);
        check("xfer_pass", pass, mon_e.ps);
        check("xfer_busy", busy, mon_e.bs);
      end
    end
  end

  always @(negedge clk) begin
    if (code_error) ce_count++;
  end

  // Called just after a negedge; returns just after the negedge following the transfer.
  task automatic send_word(input int code, input bit stall);
    bit got;
    if (stall) begin
      code_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    code_valid = 1'b1;
    code_in    = 4'(code);
    model_step(code);
    got = 0;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      if (code_ready) begin
        got = 1;
        break;
      end
    end
    @(negedge clk);
    check("transfer_timeout", got, 1);
  endtask

  task automatic start_run(input int sel);
    @(negedge clk);
    start  = 1'b1;
    select = 2'(sel);
    @(negedge clk);
    start  = 1'b0;
    select = 2'($urandom_range(0, 3));
    m_sel = sel; m_last = 0; m_err = 0; m_cnt = 0; m_first = 1;
    check("start_busy", busy, 1);
    check("start_ready", code_ready, 1);
    check("start_done", done, 0);
    check("start_word_count", word_count, 0);
    check("start_err_count", err_count, 0);
  endtask

  task automatic finish_run();
    code_valid = 1'b0;
    check("end_done", done, 1);
    check("end_pass", pass, (m_err == 0) ? 1 : 0);
    check("end_busy", busy, 0);
    check("end_ready", code_ready, 0);
    check("end_word_count", word_count, m_cnt);
    check("end_err_count", err_count, m_err);
    check("end_last_index", last_index, m_last);
  endtask

  task automatic run(input int sel, input int codes[$], input bit stall);
    start_run(sel);
    foreach (codes[i]) send_word(codes[i], stall);
    finish_run();
  endtask

  int gray[$], ex3[$], bin[$], bcd[$], rnd[$];
  int ce_before, v, c, sel, m;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; code_valid = 1'b0; select = 2'b00; code_in = 4'd0;
    #1;
    check("rst_ready", code_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_words", word_count, 0);
    check("rst_last", last_index, 0);
    check("rst_code_error", code_error, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) gray.push_back(i ^ (i >> 1));
    for (int i = 0; i < 16; i++) ex3.push_back((i % 10) + 3);
    for (int i = 0; i < 16; i++) bin.push_back(((i < 3) ? i : i + 1) & 15);
    bcd = '{0, 1, 2, 10, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5};

    // Gray, valid held high
    run(0, gray, 0);
    check("gray_last", last_index, 15);
    check("gray_pass", pass, 1);

    // No transfer while code_ready is low in DONE
    code_valid = 1'b1;
    code_in    = 4'd0;
    repeat (3) @(negedge clk);
    check("done_hold_words", word_count, 16);
    check("done_hold_done", done, 1);
    code_valid = 1'b0;

    // Excess-3 with 9->0 wrap, started from DONE
    run(1, ex3, 0);
    check("ex3_last", last_index, 5);
    check("ex3_err", err_count, 0);

    // Binary with value 3 skipped
    run(2, bin, 0);
    check("bin_err", err_count, 1);
    check("bin_pass", pass, 0);

    // BCD with one illegal word and resync
    ce_before = ce_count;
    run(3, bcd, 0);
    check("bcd_err", err_count, 1);
    check("bcd_code_error_pulses", ce_count - ce_before, 1);

    // Start ignored mid-run, then asynchronous reset
    start_run(0);
    send_word(gray[0], 0);
    send_word(gray[1], 0);
    start  = 1'b1;
    select = 2'b01;
    send_word(gray[2], 0);
    start = 1'b0;
    send_word(gray[3], 0);
    send_word(gray[4], 0);
    code_valid = 1'b0;
    check("midrun_err", err_count, 0);
    check("midrun_words", word_count, 5);
    check("midrun_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", code_ready, 0);
    check("async_rst_words", word_count, 0);
    check("async_rst_last", last_index, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle_ready", code_ready, 0);
    check("post_rst_idle_done", done, 0);
    run(0, gray, 0);
    check("post_rst_pass", pass, 1);

    // Gray with random stalls
    run(0, gray, 1);
    check("stall_last", last_index, 15);
    check("stall_pass", pass, 1);

    // Random runs: random code type, random start point, occasional corrupted words
    for (int r = 0; r < 6; r++) begin
      sel = $urandom_range(0, 3);
      m   = modulus(sel);
      v   = $urandom_range(0, m - 1);
      rnd.delete();
      for (int i = 0; i < 16; i++) begin
        c = encode(sel, v);
        if ($urandom_range(0, 4) == 0) c = $urandom_range(0, 15);
        rnd.push_back(c);
        v = (v + 1) % m;
      end
      run(sel, rnd, 1);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
